team_00_walk_monitor: RTL and testbench
=======================================

# team_00_walk_monitor

Receive-side checker for the walking-one GPIO sequence: samples the 34 GPIO inputs, verifies one bit advances from GPIO[0] to GPIO[33] then all-zero, once every `prescaler` ms, and reports progress, timing and errors on the logic analyzer. It sits in the team project wrapper in the same slot as the sequencer, pin-compatible with it, so a second chip or loopback can check a sequencer's pins.

## Interface
- `CYCLES_PER_MS`, default 10000: clock cycles per ms (100 ns clock).
- `TOL`, default 4: allowed ± cycle deviation per step interval.
- `clk` in 1: system clock.
- `nrst` in 1: asynchronous, active-low reset.
- `en` in 1: block enable; low behaves as clear.
- `prescaler` in 14: expected step period in ms, latched at arm.
- `done` out 1: one-cycle pulse per completed sequence.
- `la_data_in` in 128: [0] arm, [1] clear; others ignored.
- `la_data_out` out 128: status (see Operation).
- `la_oenb` in 128: ignored.
- `gpio_in` in 34: monitored pattern.
- `gpio_out` out 34: constant 0.
- `gpio_oeb` out 34: constant all-ones (all pins inputs).

## Operation
- `gpio_in` passes through a 2-flop synchronizer; `vec` = synchronized value, `prev` = `vec` delayed one cycle; change event = `vec != prev`.
- States: IDLE, WAIT_FIRST, TRACK, ERROR.
  - IDLE -> WAIT_FIRST: `en & la_data_in[0] & ~la_data_in[1]`.
    - Latch `limit = prescaler*CYCLES_PER_MS` (28 bit).
    - If `prescaler==0`: go to ERROR, code 4.
  - WAIT_FIRST:
    - `vec==0`: wait.
    - `vec==34'd1`: go to TRACK, idx=0, cycle counter cleared.
    - Any other value: ERROR, code 1.
  - TRACK, on change event:
    - Next expected value is `1<<(idx+1)` for idx<33, and 0 for idx==33.
    - Match: accept the step, record interval, clear counter.
    - Zero accepted: pulse `done`, seq_count += 1 (saturating 16 bit), idx=34.
    - From idx 34 the expected value is 34'd1 (timed); accepting it sets idx=0.
    - Non-match: ERROR, code 1.
  - TRACK timing:
    - Step with counter < limit−TOL: code 2 (early).
    - Counter reaching limit+TOL+1 with no event: code 3 (late).
  - ERROR: sticky; idx and status frozen.
- Clear: `la_data_in[1]` or `en==0` forces IDLE from any state and zeroes all status. Clear has priority over arm in the same cycle. Arm is level-sensitive, so holding arm after clear re-arms.
- `la_data_out` fields:
  - [0] tracking (WAIT_FIRST or TRACK).
  - [1] error.
  - [4:2] error code.
  - [10:5] idx.
  - [26:11] seq_count.
  - [54:27] last accepted interval (cycles).
  - [127:55] = 0.

## Timing
- Reset values: all outputs 0 except `gpio_oeb` = all-ones. State is IDLE; counters, idx and latched limit are 0.
- A reset mid-sequence returns to IDLE immediately; no `done` is produced.
- Latency from `gpio_in` change to status/`done` update: 3 cycles (2 sync + 1 register).
- Error codes 1/2: flagged 3 cycles after the offending input edge.
- Error code 3: flagged on the cycle the counter equals limit+TOL+1.
- Arm to WAIT_FIRST: 1 cycle. Clear to zeroed status: 1 cycle.
- The cycle counter is 28 bit and saturates; no wrap.
- Strict checking: any single-cycle illegal synchronized vector is an error.

## Configuration
- `WALK_MON_TIMING_CHECK_EN` defined:
  - Cycle counter, limit register and interval field are present.
  - Codes 2 and 3 are active.
- Not defined:
  - Only ordering is checked; codes 2/3 never occur.
  - No counter or multiplier is synthesized; bits [54:27] read 0.
  - Code 4 is still checked.

## Structure
- `team_00_pkg` holds:
  - state enum `walk_mon_state_t`;
  - error code constants (`ERR_NONE`=0, `ERR_ORDER`=1, `ERR_EARLY`=2, `ERR_LATE`=3, `ERR_PRESCALE`=4);
  - `la_data_out` field offsets.
- One sub-module, `gpio_sync2`: a parameterized-width 2-flop synchronizer with asynchronous active-low reset.

## Test plan
- Reset, no arm: `la_data_out`=0, `gpio_out`=0, `gpio_oeb`=34'h3_FFFF_FFFF, `done`=0.
- Arm with prescaler=1; drive an ideal pattern (10000 cycles per step, 34 bits then 0) twice:
  - two `done` pulses;
  - seq_count=2, error=0;
  - last interval=10000.
- Order fault: drive 1<<5 then 1<<7 -> error=1, code=1, idx=5, asserted 3 cycles after the edge.
- Timing faults with prescaler=1, TOL=4:
  - step after 9990 cycles -> code 2;
  - rerun, hold a bit for 10005 cycles -> code 3.
- Clear handling:
  - assert `la_data_in[1]` mid-TRACK -> status all-zero next cycle, state IDLE;
  - `la_data_in[1:0]=2'b11` -> stays IDLE;
  - `en=0` -> same as clear.
- Arm with prescaler=0 -> error code 4 one cycle later.
- Build without `WALK_MON_TIMING_CHECK_EN`; step after 100 cycles -> no error, bits [54:27]=0.

Source files
------------

// File: rtl/team_00_pkg.sv
// Shared types and constants for the walking-one receive monitor.
package team_00_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_TRACK,
    ST_ERROR
  } walk_mon_state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ORDER    = 3'd1;
  localparam logic [2:0] ERR_EARLY    = 3'd2;
  localparam logic [2:0] ERR_LATE     = 3'd3;
  localparam logic [2:0] ERR_PRESCALE = 3'd4;

  localparam int LA_TRK_BIT  = 0;
  localparam int LA_ERR_BIT  = 1;
  localparam int LA_CODE_LSB = 2;
  localparam int LA_IDX_LSB  = 5;
  localparam int LA_SEQ_LSB  = 11;
  localparam int LA_IVL_LSB  = 27;

  localparam int         GPIO_W   = 34;
  localparam logic [5:0] IDX_LAST = 6'd33;
  localparam logic [5:0] IDX_WRAP = 6'd34;

  // idx 33 expects the all-zero gap, idx 34 expects the restart at bit 0.
  function automatic logic [GPIO_W-1:0] walk_expect(input logic [5:0] idx);
    logic [GPIO_W-1:0] v;
    v = '0;
    if (idx == IDX_WRAP) v = 34'd1;
    else if (idx < IDX_LAST) v = 34'd1 << (idx + 6'd1);
    return v;
  endfunction

endpackage

// File: rtl/team_00_walk_monitor_gpio_sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset.
module gpio_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/team_00_walk_monitor.sv
// Walking-one receive checker: verifies order and step timing of gpio_in.
// Define WALK_MON_TIMING_CHECK_EN to add the step-interval counter (codes 2/3).
module team_00_walk_monitor
  import team_00_pkg::*;
#(
  parameter int CYCLES_PER_MS = 10000,
  parameter int TOL           = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic [13:0]  prescaler,
  output logic         done,
  input  logic [127:0] la_data_in,
  output logic [127:0] la_data_out,
  input  logic [127:0] la_oenb,
  input  logic [33:0]  gpio_in,
  output logic [33:0]  gpio_out,
  output logic [33:0]  gpio_oeb
);

  // Handshake: none; arm (la_data_in[0]) is level-sensitive in IDLE, clear
  // (la_data_in[1] or en low) wins over arm and acts on the next edge.

  walk_mon_state_t   r_state;
  logic [2:0]        r_code;
  logic [5:0]        r_idx;
  logic [15:0]       r_seq;
  logic              r_done;
  logic [GPIO_W-1:0] r_prev;
  logic [GPIO_W-1:0] w_vec;
  logic [GPIO_W-1:0] w_expect;
  logic              w_change;
  logic              w_clr;
  logic              w_arm;
  logic              w_unused;
  logic [127:0]      w_la;

  gpio_sync2 #(.W(GPIO_W)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (gpio_in),
    .q    (w_vec)
  );

  assign w_change = (w_vec != r_prev);
  assign w_expect = walk_expect(r_idx);
  assign w_clr    = la_data_in[1] | ~en;
  assign w_arm    = en & la_data_in[0] & ~la_data_in[1];

`ifdef WALK_MON_TIMING_CHECK_EN
  localparam logic [29:0] TOL_W = 30'(TOL);
  logic [27:0] r_limit;
  logic [27:0] r_cnt;
  logic [27:0] r_ivl;
  logic [27:0] w_cnt_nxt;
  logic [27:0] w_limit_arm;
  logic        w_early;
  logic        w_late;

  // w_cnt_nxt is the number of cycles elapsed since the last accepted step.
  assign w_cnt_nxt   = (r_cnt == '1) ? r_cnt : r_cnt + 28'd1;
  assign w_limit_arm = 28'({18'd0, prescaler} * 32'(CYCLES_PER_MS));
  assign w_early     = ({2'b0, w_cnt_nxt} + TOL_W) < {2'b0, r_limit};
  assign w_late      = {2'b0, w_cnt_nxt} > ({2'b0, r_limit} + TOL_W);
  assign w_unused    = ^{1'b0, la_data_in[127:2], la_oenb};
`else
  assign w_unused    = ^{1'b0, la_data_in[127:2], la_oenb, 32'(CYCLES_PER_MS), 32'(TOL)};
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_code  <= ERR_NONE;
      r_idx   <= '0;
      r_seq   <= '0;
      r_done  <= 1'b0;
      r_prev  <= '0;
`ifdef WALK_MON_TIMING_CHECK_EN
      r_limit <= '0;
      r_cnt   <= '0;
      r_ivl   <= '0;
`endif
    end else begin
      r_prev <= w_vec;
      r_done <= 1'b0;
      if (w_clr) begin
        r_state <= ST_IDLE;
        r_code  <= ERR_NONE;
        r_idx   <= '0;
        r_seq   <= '0;
`ifdef WALK_MON_TIMING_CHECK_EN
        r_limit <= '0;
        r_cnt   <= '0;
        r_ivl   <= '0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_arm) begin
`ifdef WALK_MON_TIMING_CHECK_EN
              r_limit <= w_limit_arm;
`endif
              if (prescaler == 14'd0) begin
                r_state <= ST_ERROR;
                r_code  <= ERR_PRESCALE;
              end else begin
                r_state <= ST_WAIT_FIRST;
              end
            end
          end
          ST_WAIT_FIRST: begin
            if (w_vec == 34'd1) begin
              r_state <= ST_TRACK;
              r_idx   <= '0;
`ifdef WALK_MON_TIMING_CHECK_EN
              r_cnt   <= '0;
`endif
            end else if (w_vec != '0) begin
              r_state <= ST_ERROR;
              r_code  <= ERR_ORDER;
            end
          end
          ST_TRACK: begin
            if (w_change) begin
              if (w_vec != w_expect) begin
                r_state <= ST_ERROR;
                r_code  <= ERR_ORDER;
`ifdef WALK_MON_TIMING_CHECK_EN
              end else if (w_early) begin
                r_state <= ST_ERROR;
                r_code  <= ERR_EARLY;
              end else if (w_late) begin
                r_state <= ST_ERROR;
                r_code  <= ERR_LATE;
`endif
              end else begin
`ifdef WALK_MON_TIMING_CHECK_EN
                r_ivl <= w_cnt_nxt;
                r_cnt <= '0;
`endif
                if (r_idx == IDX_WRAP) begin
                  r_idx <= '0;
                end else if (r_idx == IDX_LAST) begin
                  r_idx  <= IDX_WRAP;
                  r_done <= 1'b1;
                  if (r_seq != '1) r_seq <= r_seq + 16'd1;
                end else begin
                  r_idx <= r_idx + 6'd1;
                end
              end
            end
`ifdef WALK_MON_TIMING_CHECK_EN
            else if (w_late) begin
              r_state <= ST_ERROR;
              r_code  <= ERR_LATE;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_la = '0;
    w_la[LA_TRK_BIT]        = (r_state == ST_WAIT_FIRST) || (r_state == ST_TRACK);
    w_la[LA_ERR_BIT]        = (r_state == ST_ERROR);
    w_la[LA_CODE_LSB +: 3]  = r_code;
    w_la[LA_IDX_LSB +: 6]   = r_idx;
    w_la[LA_SEQ_LSB +: 16]  = r_seq;
`ifdef WALK_MON_TIMING_CHECK_EN
    w_la[LA_IVL_LSB +: 28]  = r_ivl;
`endif
  end

  assign la_data_out = w_la;
  assign done        = r_done;
  assign gpio_out    = '0;
  assign gpio_oeb    = '1;

endmodule

// File: tb/tb_team_00_walk_monitor.sv
// Self-checking bench for team_00_walk_monitor (scaled to 100 cycles per ms).
module tb_team_00_walk_monitor;

  localparam int CPM   = 100;
  localparam int TOL_P = 4;
`ifdef WALK_MON_TIMING_CHECK_EN
  localparam logic [27:0] IVL_MASK = '1;
`else
  localparam logic [27:0] IVL_MASK = '0;
`endif

  typedef struct {
    logic [33:0] gpio;
    int          hold;
    logic        trk;
    logic        err;
    logic [2:0]  code;
    logic [5:0]  idx;
    logic [15:0] seq;
    logic [27:0] ivl;
  } vec_t;

  logic         clk;
  logic         nrst;
  logic         en;
  logic [13:0]  prescaler;
  logic         done;
  logic [127:0] la_data_in;
  logic [127:0] la_data_out;
  logic [127:0] la_oenb;
  logic [33:0]  gpio_in;
  logic [33:0]  gpio_out;
  logic [33:0]  gpio_oeb;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  logic [31:0] exp_q[$];
  vec_t tbl[70];

  team_00_walk_monitor #(.CYCLES_PER_MS(CPM), .TOL(TOL_P)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .prescaler   (prescaler),
    .done        (done),
    .la_data_in  (la_data_in),
    .la_data_out (la_data_out),
    .la_oenb     (la_oenb),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oeb    (gpio_oeb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] st(input logic trk, input logic err, input logic [2:0] code,
                                      input logic [5:0] idx, input logic [15:0] seq,
                                      input logic [27:0] ivl);
    logic [127:0] v;
    v = '0;
    v[0]     = trk;
    v[1]     = err;
    v[4:2]   = code;
    v[10:5]  = idx;
    v[26:11] = seq;
    v[54:27] = ivl & IVL_MASK;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // every wait goes through here so done pulses are scoreboarded each cycle
  task automatic wait_cycles(input int n);
    logic hit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hit = 1'b0;
      if (exp_q.size() > 0) begin
        if (exp_q[0] == 32'(cyc)) hit = 1'b1;
      end
      if (hit) begin
        void'(exp_q.pop_front());
        check($sformatf("done_pulse@%0d", cyc), {127'd0, done}, 128'd1);
      end else if (done !== 1'b0) begin
        check($sformatf("done_spurious@%0d", cyc), {127'd0, done}, 128'd0);
      end
    end
  endtask

  task automatic drive_step(input logic [33:0] v, input int hold);
    gpio_in = v;
    wait_cycles(hold);
  endtask

  task automatic do_clear_and_arm();
    la_data_in = 128'd2;
    gpio_in    = '0;
    wait_cycles(3);
    la_data_in = 128'd1;
    wait_cycles(1);
    la_data_in = 128'd0;
  endtask

  initial begin
    logic [33:0] one;
    one = 34'd1;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 35; k++) begin
        tbl[s*35+k].gpio = (k < 34) ? (one << k) : 34'd0;
        tbl[s*35+k].hold = CPM;
        tbl[s*35+k].trk  = 1'b1;
        tbl[s*35+k].err  = 1'b0;
        tbl[s*35+k].code = 3'd0;
        tbl[s*35+k].idx  = 6'(k);
        tbl[s*35+k].seq  = 16'(s + ((k == 34) ? 1 : 0));
        tbl[s*35+k].ivl  = (s == 0 && k == 0) ? 28'd0 : 28'(CPM);
      end
    end

    nrst = 1'b0; en = 1'b0; prescaler = 14'd1;
    la_data_in = '0; la_oenb = '0; gpio_in = '0;
    wait_cycles(3);
    check("rst_la_out", la_data_out, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    nrst = 1'b1;
    wait_cycles(2);
    check("idle_la_out", la_data_out, 128'd0);
    check("idle_gpio_out", {94'd0, gpio_out}, 128'd0);
    check("idle_gpio_oeb", {94'd0, gpio_oeb}, {94'd0, 34'h3_FFFF_FFFF});

    // ideal sequence, twice
    en = 1'b1;
    la_data_in = 128'd1;
    wait_cycles(1);
    check("arm_wait_first", la_data_out, st(1, 0, 3'd0, 6'd0, 16'd0, 28'd0));
    la_data_in = 128'd0;
    for (int i = 0; i < 70; i++) begin
      gpio_in = tbl[i].gpio;
      if (tbl[i].gpio == 34'd0) exp_q.push_back(32'(cyc + 3));
      wait_cycles(tbl[i].hold);
      check($sformatf("walk_step%0d", i), la_data_out,
            st(tbl[i].trk, tbl[i].err, tbl[i].code, tbl[i].idx, tbl[i].seq, tbl[i].ivl));
    end
    check("done_all_seen", 128'(exp_q.size()), 128'd0);

    // clear mid-TRACK
    la_data_in = 128'd2;
    wait_cycles(1);
    check("clear_mid_track", la_data_out, 128'd0);
    la_data_in = 128'd1;
    wait_cycles(1);
    check("rearm_after_clear", la_data_out, st(1, 0, 3'd0, 6'd0, 16'd0, 28'd0));
    la_data_in = 128'd0;

    // order fault: 1..1<<5 then 1<<7
    for (int k = 0; k < 6; k++) drive_step(one << k, CPM);
    drive_step(one << 7, 2);
    check("order_pre_edge", la_data_out, st(1, 0, 3'd0, 6'd5, 16'd0, 28'(CPM)));
    wait_cycles(1);
    check("order_fault", la_data_out, st(0, 1, 3'd1, 6'd5, 16'd0, 28'(CPM)));
    wait_cycles(5);
    check("order_sticky", la_data_out, st(0, 1, 3'd1, 6'd5, 16'd0, 28'(CPM)));

    // clear beats arm; level arm re-arms; en low clears
    la_data_in = 128'd3;
    gpio_in = '0;
    wait_cycles(3);
    check("clr_arm_idle", la_data_out, 128'd0);
    la_data_in = 128'd1;
    wait_cycles(1);
    check("held_arm_rearms", la_data_out, st(1, 0, 3'd0, 6'd0, 16'd0, 28'd0));
    en = 1'b0;
    wait_cycles(1);
    check("en_low_clears", la_data_out, 128'd0);
    en = 1'b1;
    wait_cycles(1);
    check("en_high_rearms", la_data_out, st(1, 0, 3'd0, 6'd0, 16'd0, 28'd0));
    la_data_in = 128'd0;

`ifdef WALK_MON_TIMING_CHECK_EN
    // early, with both tolerance boundaries accepted first
    drive_step(34'd1, CPM);
    drive_step(34'd2, CPM - TOL_P);
    drive_step(34'd4, CPM + TOL_P);
    check("tol_low_edge", la_data_out, st(1, 0, 3'd0, 6'd2, 16'd0, 28'(CPM - TOL_P)));
    drive_step(34'd8, CPM - 10);
    check("tol_high_edge", la_data_out, st(1, 0, 3'd0, 6'd3, 16'd0, 28'(CPM + TOL_P)));
    drive_step(34'd16, 2);
    check("early_pre_edge", la_data_out, st(1, 0, 3'd0, 6'd3, 16'd0, 28'(CPM + TOL_P)));
    wait_cycles(1);
    check("early_fault", la_data_out, st(0, 1, 3'd2, 6'd3, 16'd0, 28'(CPM + TOL_P)));

    // late: no event after step 2
    do_clear_and_arm();
    drive_step(34'd1, CPM);
    drive_step(34'd2, CPM + TOL_P + 3);
    check("late_pre", la_data_out, st(1, 0, 3'd0, 6'd1, 16'd0, 28'(CPM)));
    wait_cycles(1);
    check("late_fault", la_data_out, st(0, 1, 3'd3, 6'd1, 16'd0, 28'(CPM)));
`else
    drive_step(34'd1, 10);
    drive_step(34'd2, 10);
    drive_step(34'd4, 3 * CPM);
    check("no_timing_fast", la_data_out, st(1, 0, 3'd0, 6'd2, 16'd0, 28'd0));
    check("no_timing_ivl_zero", {100'd0, la_data_out[54:27]}, 128'd0);
`endif

    // prescaler 0
    prescaler = 14'd0;
    do_clear_and_arm();
    check("prescale_zero", la_data_out, st(0, 1, 3'd4, 6'd0, 16'd0, 28'd0));
    wait_cycles(5);
    check("prescale_sticky", la_data_out, st(0, 1, 3'd4, 6'd0, 16'd0, 28'd0));

    // async reset mid-sequence
    prescaler = 14'd1;
    do_clear_and_arm();
    drive_step(34'd1, CPM);
    drive_step(34'd2, CPM);
    drive_step(34'd4, 2);
    nrst = 1'b0;
    #1;
    check("midrst_la_out", la_data_out, 128'd0);
    check("midrst_done", {127'd0, done}, 128'd0);
    wait_cycles(2);
    nrst = 1'b1;
    wait_cycles(5);
    check("post_rst_idle", la_data_out, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
